pc_fetch_ctrl: RTL and testbench

- Program-counter register and next-PC selector for the IF stage of the pipelined MIPS core.
- Consumes the sequential increment, branch/jump redirects from ID, and exception redirects from the CP0 path.
- Drives the instruction-memory fetch address and the PC+4 value that travels down the pipeline.
- Buffers a redirect that arrives while IF is stalled, so a branch resolved during a hazard stall is not lost.

---
 rtl/pc_fetch_ctrl.sv | 100 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter with next-PC selection and a one-entry redirect buffer for stalls.
// Optional misaligned-fetch flag (adel) is built only when PC_ALIGN_CHK_EN is defined.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        pending,
  output logic        adel
);

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        fetch_valid_q;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      pend_pc_q     <= 32'h0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      fetch_valid_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    // The first edge out of reset only raises fetch_valid; RESET_PC is fetched as-is.
    if (!fetch_valid_q) begin
      state_d = StRun;
    end else if (exc_req) begin
      pc_d      = EXC_VECTOR;
      pend_pc_d = 32'h0;
      state_d   = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (!stall) begin
            pc_d = redirect_valid ? redirect_pc : pc_plus4;
          end else if (redirect_valid) begin
            pend_pc_d = redirect_pc;
            state_d   = StHold;
          end
        end
        StHold: begin
          if (stall) begin
            if (redirect_valid) pend_pc_d = redirect_pc;
          end else begin
            // A redirect arriving on the release cycle is younger than the buffered one.
            pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

`ifdef PC_ALIGN_CHK_EN
  logic adel_q, adel_d;

  always_comb begin
    adel_d = |pc_d[1:0];
    if (fetch_valid_q && exc_req) adel_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) adel_q <= 1'b0;
    else       adel_q <= adel_d;
  end

  assign adel = adel_q;
`else
  assign adel = 1'b0;
`endif

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign pending     = (state_q == StHold);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed plan plus randomized traffic against a
// behavioural model (PC_ALIGN_CHK_EN selects the expected adel behaviour).
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        exc_req = 1'b0;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, pending, adel;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model.
  logic [31:0] m_pc      = RST_PC;
  logic [31:0] m_pend_pc = 32'h0;
  logic        m_pend    = 1'b0;
  logic        m_fv      = 1'b0;

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_req        (exc_req),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_valid    (fetch_valid),
    .pending        (pending),
    .adel           (adel)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= RST_PC; m_pend <= 1'b0; m_pend_pc <= 32'h0; m_fv <= 1'b0;
    end else if (!m_fv) begin
      m_fv <= 1'b1;
    end else if (exc_req) begin
      m_pc <= EXC_PC; m_pend <= 1'b0; m_pend_pc <= 32'h0;
    end else if (!stall) begin
      m_pc   <= redirect_valid ? redirect_pc : (m_pend ? m_pend_pc : m_pc + 32'd4);
      m_pend <= 1'b0;
    end else if (redirect_valid) begin
      m_pend <= 1'b1; m_pend_pc <= redirect_pc;
    end
  end

  function automatic logic exp_adel(input logic [31:0] p);
`ifdef PC_ALIGN_CHK_EN
    return |p[1:0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_pc", pc, m_pc);
    chk("model_pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("model_fetch_valid", {31'h0, fetch_valid}, {31'h0, m_fv});
    chk("model_pending", {31'h0, pending}, {31'h0, m_pend});
    chk("model_adel", {31'h0, adel}, {31'h0, exp_adel(m_pc)});
  end

  // Applies inputs just after a falling edge and returns after the next falling edge.
  task automatic step(input logic s, input logic rv, input logic [31:0] rp, input logic e);
    #1;
    stall = s; redirect_valid = rv; redirect_pc = rp; exc_req = e;
    @(negedge clk);
  endtask

  task automatic release_reset();
    #1 reset = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset and sequential fetch.
    @(negedge clk);
    chk("reset_pc", pc, 32'h0000_3000);
    chk("reset_fv", {31'h0, fetch_valid}, 32'h0);
    chk("reset_pending", {31'h0, pending}, 32'h0);
    chk("reset_adel", {31'h0, adel}, 32'h0);
    release_reset();
    chk("first_edge_pc", pc, 32'h0000_3000);
    chk("first_edge_fv", {31'h0, fetch_valid}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("seq_3004", pc, 32'h0000_3004);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("seq_3008", pc, 32'h0000_3008);
    chk("seq_plus4", pc_plus4, 32'h0000_300C);

    // Unstalled redirect.
    step(1'b0, 1'b1, 32'h0000_3100, 1'b0);
    chk("redir_3100", pc, 32'h0000_3100);
    chk("redir_no_pending", {31'h0, pending}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_3104", pc, 32'h0000_3104);

    // Redirect during stall, overwrite, then simultaneous redirect on release.
    step(1'b1, 1'b1, 32'h0000_3200, 1'b0);
    chk("stall_hold_pc", pc, 32'h0000_3104);
    chk("stall_pending", {31'h0, pending}, 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("stall_hold_pc2", pc, 32'h0000_3104);
    step(1'b1, 1'b1, 32'h0000_3300, 1'b0);
    step(1'b0, 1'b1, 32'h0000_3400, 1'b0);
    chk("release_newest", pc, 32'h0000_3400);
    chk("release_pending", {31'h0, pending}, 32'h0);

    // Plain release uses the buffered target.
    step(1'b1, 1'b1, 32'h0000_3200, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("release_buffered", pc, 32'h0000_3200);

    // Exception beats stall, pending and a simultaneous redirect.
    step(1'b1, 1'b1, 32'h0000_3000, 1'b0);
    step(1'b1, 1'b1, 32'h0000_3500, 1'b1);
    chk("exc_pc", pc, 32'h0000_4180);
    chk("exc_pending", {31'h0, pending}, 32'h0);

    // Reset during HOLD acts immediately.
    step(1'b1, 1'b1, 32'h0000_3600, 1'b0);
    chk("hold_before_reset", {31'h0, pending}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_pc", pc, 32'h0000_3000);
    chk("async_reset_pending", {31'h0, pending}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    release_reset();

    // Misaligned target and wrap-around.
    step(1'b0, 1'b1, 32'h0000_3102, 1'b0);
    chk("misalign_pc", pc, 32'h0000_3102);
    chk("misalign_adel", {31'h0, adel}, {31'h0, exp_adel(32'h0000_3102)});
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("exc_clears_pc", pc, 32'h0000_4180);
    chk("exc_clears_adel", {31'h0, adel}, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("wrap_plus4", pc_plus4, 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc", pc, 32'h0000_0000);

    // Randomized traffic; the model checker covers every cycle.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        release_reset();
      end else begin
        logic [31:0] rp;
        rp = {$urandom_range(0, 32'h3FFF), 2'b00} + 32'h3000;
        if ($urandom_range(0, 9) == 0) rp[1:0] = 2'($urandom_range(1, 3));
        step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, rp,
             $urandom_range(0, 19) == 0);
      end
    end

    step(1'b0, 1'b0, 32'h0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
